arbiter_round_robin_wlock: RTL and testbench
============================================

// Module: arbiter_round_robin_wlock
// PURPOSE
//  Parametrised weighted round-robin arbiter with packet lock for switch/VC allocation.
//  Grants one requester per cycle. Holds the grant on its owner from head flit to tail flit (wormhole).
//  Serves each requester up to its weight in consecutive packets before the priority pointer moves on.
//  Drop-in successor to arbiter_round_robin inside the router SA/VA stages.
// PARAMETERS
//  NUM_REQS  4  number of requesters (>=2)
//  WEIGHT_W  3  bits per weight field; weight 0 is treated as 1
//  ID_W      $clog2(NUM_REQS)  width of grant_id (localparam)
// PORTS
//  clk          in   1                  clock, rising edge
//  reset        in   1                  asynchronous, active-low reset
//  enable       in   1                  downstream can accept a flit this cycle
//  requests     in   NUM_REQS           per-requester flit-valid
//  tails        in   NUM_REQS           flit presented by requester i is a tail (single-flit pkt: 1)
//  weights      in   NUM_REQS*WEIGHT_W  packets per turn; field i = [i*WEIGHT_W +: WEIGHT_W]
//  grants       out  NUM_REQS           one-hot grant, combinational from state + inputs
//  grant_valid  out  1                  |grants
//  grant_id     out  ID_W               index of the granted bit (0 when no grant)
//  locked       out  1                  state == LOCKED
// BEHAVIOUR
//  State: ptr[ID_W], cnt[WEIGHT_W], owner[ID_W], fsm {IDLE, LOCKED}.
//  Reset (reset==0, async): ptr=0, cnt=0, owner=0, fsm=IDLE. grants/grant_valid/grant_id/locked forced 0 while asserted.
//  Grant, 0-cycle latency:
//   - enable==0: grants=0; no state change.
//   - IDLE: g = first set bit of requests, scanning ptr, ptr+1, ..., wrapping at NUM_REQS-1 -> 0. grants=1<<g. No requests -> 0.
//   - LOCKED: grants = requests[owner] ? 1<<owner : 0. Other requesters are never granted, even when owner is idle.
//  Every cycle with grant_valid=1 transfers exactly one flit from g. Updates at the next clk edge:
//   - tails[g]==0: fsm=LOCKED, owner=g. If already LOCKED, stay.
//   - tails[g]==1 (packet completes): fsm=IDLE. Then:
//     - n = (g==ptr) ? cnt+1 : 1; w = max(weight[g],1), sampled this cycle.
//     - n >= w: ptr = (g==NUM_REQS-1) ? 0 : g+1; cnt=0.
//     - else: ptr=g; cnt=n.
//  cnt arithmetic in WEIGHT_W+1 bits; no overflow because n <= 2^WEIGHT_W-1 before reset to 0.
//  Weights may change at any time; they only matter at completion. A lowered weight with cnt >= new w moves ptr on at the next completion.
//  Simultaneous events: a single-flit packet in IDLE never enters LOCKED. A tail in LOCKED releases, and a new head can win in the following cycle.
//  Async reset mid-packet: lock dropped, ptr=0. Upstream must resend from the head.
//  grants is always one-hot or zero. Assertions check $onehot0(grants), and that grants is a subset of requests.
// CONFIGURATION
//  ARB_WEIGHT_EN defined: weights used as above.
//  ARB_WEIGHT_EN undefined:
//   - weights port still present but ignored; w=1 for all requesters.
//   - cnt register removed; ptr = g+1 (wrapped) on every completion.
//   - Behaviour equals plain packet-locked round-robin.
// TESTING
//  T1 reset: reset=0 with requests=4'b1111 -> grants=0, locked=0. Release reset, enable=1, all tails=1 -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
//  T2 lock: requests=4'b0101, tails=0, 3 cycles, then tails[0]=1 -> grants=0001 for 4 cycles with locked=1 for cycles 2-4. Next cycle grants=0100.
//  T3 bubble in lock: owner=1 locked, requests[1] drops for 2 cycles while requests[3]=1 -> grants=0 both cycles, locked stays 1. requests[1] returns -> grants=0010.
//  T4 weights (EN): weights={1,1,1,3}, all requesting single-flit -> grant_id sequence 0,0,0,1,2,3,0,0,0. Undefined macro -> 0,1,2,3,0.
//  T5 enable/wrap: requests=4'b1001, ptr=3, enable=0 for 2 cycles -> grants=0, no state change. enable=1 -> grant 1000, then 0001 (wrap).
//  T6 weight 0 / reset mid-op: weight[2]=0 behaves as 1. Assert reset while locked on 2 -> locked=0 immediately. After release, first grant follows ptr=0.

Source files
------------

// File: rtl/arbiter_round_robin_wlock_if.sv
// Request/grant bundle for arbiter_round_robin_wlock.
// master drives requests, tails, weights and enable; slave is the arbiter.
interface arbiter_round_robin_wlock_if #(
  parameter int NUM_REQS = 4,
  parameter int WEIGHT_W = 3
);
  localparam int ID_W = $clog2(NUM_REQS);

  logic                         enable;
  logic [NUM_REQS-1:0]          requests;
  logic [NUM_REQS-1:0]          tails;
  logic [NUM_REQS*WEIGHT_W-1:0] weights;
  logic [NUM_REQS-1:0]          grants;
  logic                         grant_valid;
  logic [ID_W-1:0]              grant_id;
  logic                         locked;

  modport master (
    output enable, requests, tails, weights,
    input  grants, grant_valid, grant_id, locked
  );

  modport slave (
    input  enable, requests, tails, weights,
    output grants, grant_valid, grant_id, locked
  );
endinterface

// File: rtl/arbiter_round_robin_wlock.sv
// Weighted round-robin arbiter that holds a grant from head to tail flit.
// Define ARB_WEIGHT_EN to honour per-requester weights; otherwise every weight is 1.
module arbiter_round_robin_wlock #(
  parameter int NUM_REQS = 4,
  parameter int WEIGHT_W = 3
) (
  input logic                         clk,
  input logic                         reset,
  arbiter_round_robin_wlock_if.slave  bus
);

  localparam int ID_W = $clog2(NUM_REQS);
  localparam int CW   = WEIGHT_W + 1;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     g;
  logic [ID_W-1:0]     g_next;
  logic                hit;
  logic                fire;
  logic [NUM_REQS-1:0] grants_int;

`ifdef ARB_WEIGHT_EN
  logic [WEIGHT_W-1:0] cnt_q, cnt_d;
  logic [WEIGHT_W-1:0] wfield;
  logic [CW-1:0]       n;
  logic [CW-1:0]       w;
`endif

  // Winner selection: the owner while locked, otherwise the first requester at or after ptr.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    g          = '0;
    hit        = 1'b0;
    grants_int = '0;
    if (state_q == LOCKED) begin
      g   = owner_q;
      hit = bus.requests[owner_q];
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (!hit && bus.requests[(int'(ptr_q) + i) % NUM_REQS]) begin
          hit = 1'b1;
          g   = ID_W'((int'(ptr_q) + i) % NUM_REQS);
        end
      end
    end
    if (reset && bus.enable && hit) grants_int[g] = 1'b1;
  end

  assign fire   = |grants_int;
  assign g_next = (g == ID_W'(NUM_REQS - 1)) ? '0 : g + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
`ifdef ARB_WEIGHT_EN
    cnt_d   = cnt_q;
    wfield  = '0;
    n       = '0;
    w       = '0;
`endif
    if (fire) begin
      if (!bus.tails[g]) begin
        state_d = LOCKED;
        owner_d = g;
      end else begin
        state_d = IDLE;
`ifdef ARB_WEIGHT_EN
        // Packets served in this turn; the turn restarts if someone other than ptr completes.
        n      = (g == ptr_q) ? ({1'b0, cnt_q} + 1'b1) : CW'(1);
        wfield = bus.weights[int'(g)*WEIGHT_W +: WEIGHT_W];
        w      = (wfield == '0) ? CW'(1) : {1'b0, wfield};
        if (n >= w) begin
          ptr_d = g_next;
          cnt_d = '0;
        end else begin
          ptr_d = g;
          cnt_d = n[WEIGHT_W-1:0];
        end
`else
        ptr_d = g_next;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
`ifdef ARB_WEIGHT_EN
      cnt_q   <= '0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
`ifdef ARB_WEIGHT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.grants      = grants_int;
  assign bus.grant_valid = fire;
  assign bus.grant_id    = fire ? g : '0;
  assign bus.locked      = reset && (state_q == LOCKED);

  a_grants_onehot: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(bus.grants));
  a_grants_subset: assert property (@(posedge clk) disable iff (!reset)
    (bus.grants & ~bus.requests) == '0);

endmodule

// File: tb/tb_arbiter_round_robin_wlock.sv
// Directed bench for arbiter_round_robin_wlock: a vector table plus hand-written
// sequences for async reset mid-packet and the weighted turn order.
module tb_arbiter_round_robin_wlock;

  localparam int NUM_REQS = 4;
  localparam int WEIGHT_W = 3;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  arbiter_round_robin_wlock_if #(.NUM_REQS(NUM_REQS), .WEIGHT_W(WEIGHT_W)) bus ();

  arbiter_round_robin_wlock #(.NUM_REQS(NUM_REQS), .WEIGHT_W(WEIGHT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic [3:0] tails;
    logic [3:0] exp_g;
    logic       exp_lk;
  } vec_t;

  vec_t vecs[$];
  int   exp_ids[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] id_of(input logic [3:0] oh);
    logic [1:0] id;
    id = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) id = 2'(i);
    return id;
  endfunction

  task automatic check_outputs(input string tag, input logic [3:0] exp_g, input logic exp_lk);
    check({tag, ".grants"},      32'(bus.grants),      32'(exp_g));
    check({tag, ".grant_valid"}, 32'(bus.grant_valid), 32'(|exp_g));
    check({tag, ".grant_id"},    32'(bus.grant_id),    32'(id_of(exp_g)));
    check({tag, ".locked"},      32'(bus.locked),      32'(exp_lk));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    // T1 tail, T2 lock, T3 bubble in lock, T5 enable/wrap; all weights 1.
    vecs.push_back('{1'b1, 4'b1111, 4'b1111, 4'b0001, 1'b0});
    vecs.push_back('{1'b1, 4'b1111, 4'b1111, 4'b0010, 1'b0});
    vecs.push_back('{1'b1, 4'b1111, 4'b1111, 4'b0100, 1'b0});
    vecs.push_back('{1'b1, 4'b1111, 4'b1111, 4'b1000, 1'b0});
    vecs.push_back('{1'b1, 4'b1111, 4'b1111, 4'b0001, 1'b0});
    vecs.push_back('{1'b1, 4'b1000, 4'b1000, 4'b1000, 1'b0});
    vecs.push_back('{1'b1, 4'b0101, 4'b0000, 4'b0001, 1'b0});
    vecs.push_back('{1'b1, 4'b0101, 4'b0000, 4'b0001, 1'b1});
    vecs.push_back('{1'b1, 4'b0101, 4'b0000, 4'b0001, 1'b1});
    vecs.push_back('{1'b1, 4'b0101, 4'b0001, 4'b0001, 1'b1});
    vecs.push_back('{1'b1, 4'b0101, 4'b0100, 4'b0100, 1'b0});
    vecs.push_back('{1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b0});
    vecs.push_back('{1'b1, 4'b1000, 4'b0000, 4'b0000, 1'b1});
    vecs.push_back('{1'b1, 4'b1000, 4'b0000, 4'b0000, 1'b1});
    vecs.push_back('{1'b1, 4'b1010, 4'b0010, 4'b0010, 1'b1});
    vecs.push_back('{1'b1, 4'b1010, 4'b1010, 4'b1000, 1'b0});
    vecs.push_back('{1'b1, 4'b0100, 4'b0100, 4'b0100, 1'b0});
    vecs.push_back('{1'b0, 4'b1001, 4'b1001, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 4'b1001, 4'b1001, 4'b0000, 1'b0});
    vecs.push_back('{1'b1, 4'b1001, 4'b1001, 4'b1000, 1'b0});
    vecs.push_back('{1'b1, 4'b1001, 4'b1001, 4'b0001, 1'b0});

`ifdef ARB_WEIGHT_EN
    exp_ids = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
`else
    exp_ids = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
`endif

    // Reset asserted with every requester active: all outputs must stay low.
    reset        = 1'b0;
    bus.enable   = 1'b1;
    bus.requests = 4'b1111;
    bus.tails    = 4'b1111;
    bus.weights  = {3'd1, 3'd1, 3'd1, 3'd1};
    @(negedge clk);
    check_outputs("reset", 4'b0000, 1'b0);
    bus.enable = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[k]) begin
      bus.enable   = vecs[k].en;
      bus.requests = vecs[k].req;
      bus.tails    = vecs[k].tails;
      @(negedge clk);
      check_outputs($sformatf("vec%0d", k), vecs[k].exp_g, vecs[k].exp_lk);
      @(posedge clk);
      #1;
    end

    // Lock onto requester 2, then drop reset mid-packet.
    bus.enable   = 1'b1;
    bus.requests = 4'b0100;
    bus.tails    = 4'b0000;
    @(negedge clk);
    check_outputs("lock2_head", 4'b0100, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_outputs("lock2_body", 4'b0100, 1'b1);
    reset = 1'b0;
    #1;
    check_outputs("async_reset", 4'b0000, 1'b0);

    // Weighted turns; weight 2 is 0 and must act as 1. ptr restarts at 0.
    bus.enable   = 1'b0;
    bus.requests = 4'b1111;
    bus.tails    = 4'b1111;
    bus.weights  = {3'd1, 3'd0, 3'd1, 3'd3};
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    bus.enable = 1'b1;
    foreach (exp_ids[k]) begin
      @(negedge clk);
      check($sformatf("weighted%0d.grant_id", k), 32'(bus.grant_id), 32'(exp_ids[k]));
      check($sformatf("weighted%0d.grants", k), 32'(bus.grants), 32'(4'b0001 << exp_ids[k]));
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
